// File: rtl/dmem_responder.sv
// dmem_responder
//   Behavioural data-memory responder for a processor data port. It accepts
//   one command per cycle, answers with a transaction tag in the same cycle,
//   and returns load data a fixed LATENCY cycles after the load was accepted.
//
//   Parameters
//     LATENCY    load-accept-to-return delay in cycles (1..20)
//     MEM_WORDS  number of 64-bit words in the backing store (power of two)
//
//   Ports
//     clock               single clock, all state changes on posedge
//     reset               synchronous, active-high; clears tags and memory
//     proc2Dmem_command   2'd0 NONE, 2'd1 LOAD, 2'd2 STORE (2'd3 acts as NONE)
//     proc2Dmem_addr      byte address; bits [2:0] and bits above the index ignored
//     proc2Dmem_data      store data
//     stall_inject        forces rejection of the current request
//     Dmem2proc_response  accept tag (1..15) in the command cycle, 0 = rejected
//     Dmem2proc_data      returned load data, 0 whenever no return happens
//     Dmem2proc_tag       tag of the load returning this cycle, 0 = none
module dmem_responder #(
  parameter int LATENCY   = 10,
  parameter int MEM_WORDS = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  proc2Dmem_command,
  input  logic [63:0] proc2Dmem_addr,
  input  logic [63:0] proc2Dmem_data,
  input  logic        stall_inject,
  output logic [3:0]  Dmem2proc_response,
  output logic [63:0] Dmem2proc_data,
  output logic [3:0]  Dmem2proc_tag
);

  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;
  localparam int         AW        = $clog2(MEM_WORDS);
  localparam logic [4:0] LAT5      = 5'(LATENCY);

  // Backing store. It must clear on reset, so it is built from flops rather
  // than a block RAM; the load path reads it combinationally in the accept cycle.
  logic [63:0] r_mem [MEM_WORDS];

  // Per-tag pending-load state; array element i belongs to tag i+1.
  logic [14:0] r_busy;
  logic [4:0]  r_cnt  [15];
  logic [63:0] r_pend [15];

  logic [AW-1:0] w_index;
  logic          w_is_req;
  logic [3:0]    w_free_tag;
  logic          w_accept;
  logic          w_load_acc;
  logic          w_store_acc;
  logic [63:0]   w_rd_word;
  logic [14:0]   w_alloc;
  logic [14:0]   w_fire;
  logic [3:0]    w_tag_term  [15];
  logic [63:0]   w_data_term [15];
  logic [3:0]    w_ret_tag;
  logic [63:0]   w_ret_data;
  logic          w_unused;

  assign w_index   = proc2Dmem_addr[AW+2:3];
  assign w_rd_word = r_mem[w_index];
  assign w_unused  = ^{proc2Dmem_addr[63:AW+3], proc2Dmem_addr[2:0]};

  assign w_is_req = ((proc2Dmem_command == BUS_LOAD) || (proc2Dmem_command == BUS_STORE))
                    && !stall_inject && !reset;

  // Lowest-numbered free tag; scanning downward leaves the smallest one.
  always_comb begin
    w_free_tag = 4'd0;
    for (int i = 14; i >= 0; i--) begin
      if (!r_busy[i]) w_free_tag = 4'(i + 1);
    end
  end

  assign w_accept           = w_is_req && (w_free_tag != 4'd0);
  assign w_load_acc         = w_accept && (proc2Dmem_command == BUS_LOAD);
  assign w_store_acc        = w_accept && (proc2Dmem_command == BUS_STORE);
  assign Dmem2proc_response = w_accept ? w_free_tag : 4'd0;

  // Per-tag allocate / expire strobes and masked return terms. A tag fires in
  // the cycle its counter shows 1, which is exactly LATENCY cycles after the
  // accept because the counter is loaded with LATENCY at the accept edge.
  genvar gi;
  generate
    for (gi = 0; gi < 15; gi++) begin : g_tag
      assign w_alloc[gi]     = w_load_acc && (w_free_tag == 4'(gi + 1));
      assign w_fire[gi]      = r_busy[gi] && (r_cnt[gi] == 5'd1);
      assign w_tag_term[gi]  = w_fire[gi] ? 4'(gi + 1) : 4'd0;
      assign w_data_term[gi] = w_fire[gi] ? r_pend[gi] : 64'd0;
    end
  endgenerate

  // Only one load is accepted per cycle, so at most one tag fires and a
  // plain OR of the masked terms selects it.
  always_comb begin
    w_ret_tag  = 4'd0;
    w_ret_data = 64'd0;
    for (int i = 0; i < 15; i++) begin
      w_ret_tag  = w_ret_tag  | w_tag_term[i];
      w_ret_data = w_ret_data | w_data_term[i];
    end
  end

  // Return path is decoded from registered state only; reset blanks it at once.
  assign Dmem2proc_tag  = reset ? 4'd0  : w_ret_tag;
  assign Dmem2proc_data = reset ? 64'd0 : w_ret_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy <= '0;
      for (int i = 0; i < 15; i++) begin
        r_cnt[i]  <= 5'd0;
        r_pend[i] <= 64'd0;
      end
    end else begin
      for (int i = 0; i < 15; i++) begin
        if (w_alloc[i]) begin
          r_busy[i] <= 1'b1;
          r_cnt[i]  <= LAT5;
          r_pend[i] <= w_rd_word;
        end else if (w_fire[i]) begin
          // Freed at the edge ending the return cycle.
          r_busy[i] <= 1'b0;
          r_cnt[i]  <= 5'd0;
        end else if (r_busy[i]) begin
          r_cnt[i] <= r_cnt[i] - 5'd1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < MEM_WORDS; i++) r_mem[i] <= 64'd0;
    end else if (w_store_acc) begin
      r_mem[w_index] <= proc2Dmem_data;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
//   Drives two responders (LATENCY 10 / 1024 words and LATENCY 20 / 64 words)
//   with one shared command stream. A reference model based on tag free times
//   and a word map predicts responses; expected returns go into per-DUT queues
//   that a separate monitor drains whenever the DUT reports a return.
module tb_dmem_responder;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;
  localparam int LAT0 = 10, LAT1 = 20, WORDS0 = 1024, WORDS1 = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  cmd   = BUS_NONE;
  logic [63:0] addr  = 64'd0;
  logic [63:0] wdata = 64'd0;
  logic        stall = 1'b0;
  logic [3:0]  resp0, resp1, tag0, tag1;
  logic [63:0] data0, data1;

  always #5 clock = ~clock;

  dmem_responder #(.LATENCY(LAT0), .MEM_WORDS(WORDS0)) dut0 (
    .clock(clock), .reset(reset), .proc2Dmem_command(cmd), .proc2Dmem_addr(addr),
    .proc2Dmem_data(wdata), .stall_inject(stall), .Dmem2proc_response(resp0),
    .Dmem2proc_data(data0), .Dmem2proc_tag(tag0));

  dmem_responder #(.LATENCY(LAT1), .MEM_WORDS(WORDS1)) dut1 (
    .clock(clock), .reset(reset), .proc2Dmem_command(cmd), .proc2Dmem_addr(addr),
    .proc2Dmem_data(wdata), .stall_inject(stall), .Dmem2proc_response(resp1),
    .Dmem2proc_data(data1), .Dmem2proc_tag(tag1));

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [3:0]  tag;
    logic [63:0] data;
  } ret_t;

  ret_t        q0[$];
  ret_t        q1[$];
  int          free_at [2][16];   // first cycle each tag may be handed out again
  logic [63:0] mem_m [int];       // key = dut*100000 + word index
  int          checks   = 0;
  int          failures = 0;

  task automatic check64(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic int mkey(int k, logic [63:0] a);
    logic [63:0] w;
    w = (a >> 3) % ((k == 0) ? 64'(WORDS0) : 64'(WORDS1));
    return k * 100000 + int'(w);
  endfunction

  function automatic logic [63:0] mread(int key);
    return mem_m.exists(key) ? mem_m[key] : 64'd0;
  endfunction

  function automatic logic [3:0] model_resp(int k, logic [1:0] c, logic s, logic r);
    if (r || s || !(c == BUS_LOAD || c == BUS_STORE)) return 4'd0;
    for (int t = 1; t <= 15; t++)
      if (free_at[k][t] <= cyc) return 4'(t);
    return 4'd0;
  endfunction

  // One bus cycle: drive after the edge, check the response mid-cycle, then
  // advance the model as the DUT will at the next edge.
  task automatic step(logic [1:0] c, logic [63:0] a, logic [63:0] d, logic s, logic r);
    logic [3:0] exp_r;
    logic [3:0] act_r;
    int         lat;
    int         key;
    @(posedge clock);
    #1;
    cmd = c; addr = a; wdata = d; stall = s; reset = r;
    @(negedge clock);
    if (r) begin
      mem_m.delete();
      q0.delete();
      q1.delete();
    end
    for (int k = 0; k < 2; k++) begin
      exp_r = model_resp(k, c, s, r);
      act_r = (k == 0) ? resp0 : resp1;
      check64((k == 0) ? "resp0" : "resp1", 64'(act_r), 64'(exp_r));
      lat = (k == 0) ? LAT0 : LAT1;
      key = mkey(k, a);
      if (r) begin
        for (int t = 0; t < 16; t++) free_at[k][t] = 0;
      end else if (exp_r != 4'd0) begin
        if (c == BUS_LOAD) begin
          free_at[k][exp_r] = cyc + lat + 1;
          if (k == 0) q0.push_back('{due: cyc + lat, tag: exp_r, data: mread(key)});
          else        q1.push_back('{due: cyc + lat, tag: exp_r, data: mread(key)});
        end else begin
          mem_m[key] = d;
        end
      end
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(BUS_NONE, 64'd0, 64'd0, 1'b0, 1'b0);
  endtask

  task automatic mon(int k, logic [3:0] tag, logic [63:0] data);
    ret_t head;
    int   n;
    if (reset) begin
      check64("rst_tag", 64'(tag), 64'd0);
      check64("rst_data", data, 64'd0);
      return;
    end
    n = (k == 0) ? q0.size() : q1.size();
    if (tag != 4'd0) begin
      if (n == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_return dut%0d cyc=%0d actual_tag=%0d required_tag=0", k, cyc, tag);
      end else begin
        head = (k == 0) ? q0.pop_front() : q1.pop_front();
        check64("ret_tag", 64'(tag), 64'(head.tag));
        check64("ret_data", data, head.data);
        check64("ret_cycle", 64'(cyc), 64'(head.due));
      end
    end else begin
      check64("idle_data", data, 64'd0);
      if (n > 0) begin
        head = (k == 0) ? q0[0] : q1[0];
        if (head.due <= cyc) begin
          checks++;
          failures++;
          $display("FAIL missing_return dut%0d cyc=%0d actual_tag=0 required_tag=%0d", k, cyc, head.tag);
          if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
      end
    end
  endtask

  always @(negedge clock) begin
    mon(0, tag0, data0);
    mon(1, tag1, data1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] ra;
    int          sel;
    for (int k = 0; k < 2; k++)
      for (int t = 0; t < 16; t++) free_at[k][t] = 0;

    for (int i = 0; i < 3; i++) step(BUS_NONE, 64'd0, 64'd0, 1'b0, 1'b1);

    // Store then load the same word.
    step(BUS_STORE, 64'h100, 64'hDEADBEEF_00000001, 1'b0, 1'b0);
    step(BUS_LOAD,  64'h100, 64'd0, 1'b0, 1'b0);
    idle(22);

    // Ten back-to-back loads, then tag reuse right after the first return.
    for (int i = 0; i < 10; i++) step(BUS_LOAD, 64'(i * 8), 64'd0, 1'b0, 1'b0);
    idle(1);
    step(BUS_LOAD, 64'h0, 64'd0, 1'b0, 1'b0);
    idle(25);

    // Load followed by a store to the same word.
    step(BUS_LOAD,  64'h40, 64'd0, 1'b0, 1'b0);
    step(BUS_STORE, 64'h40, 64'h55, 1'b0, 1'b0);
    idle(2);
    step(BUS_LOAD,  64'h40, 64'd0, 1'b0, 1'b0);
    idle(25);

    // Stall-injected load is rejected, then retried without stall.
    step(BUS_LOAD, 64'h200, 64'd0, 1'b1, 1'b0);
    idle(40);
    step(BUS_LOAD, 64'h200, 64'd0, 1'b0, 1'b0);
    idle(25);

    // Reset with three loads in flight; memory must also be cleared.
    for (int i = 0; i < 3; i++) step(BUS_LOAD, 64'h100, 64'd0, 1'b0, 1'b0);
    step(BUS_NONE, 64'd0, 64'd0, 1'b0, 1'b1);
    step(BUS_LOAD, 64'h100, 64'd0, 1'b0, 1'b1);
    idle(40);
    step(BUS_LOAD, 64'h100, 64'd0, 1'b0, 1'b0);
    idle(25);

    // Continuous loads: exhausts tags on the LATENCY 20 instance.
    for (int i = 0; i < 30; i++) step(BUS_LOAD, 64'(i * 8), 64'd0, 1'b0, 1'b0);
    idle(25);

    // Randomised traffic with aliasing addresses, stalls and rare resets.
    for (int i = 0; i < 500; i++) begin
      sel = int'($urandom_range(0, 9));
      ra  = (64'($urandom_range(0, 3)) << 9) | (64'($urandom_range(0, 7)) << 3)
            | 64'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) ra = ra | (64'd1 << 40);
      step((sel < 3) ? BUS_NONE : (sel < 7) ? BUS_LOAD : BUS_STORE, ra,
           {$urandom, $urandom}, ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 199) == 0));
    end
    idle(30);

    check64("q0_drained", 64'(q0.size()), 64'd0);
    check64("q1_drained", 64'(q1.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
